prog_delay_line: RTL

- Parametrised successor to the fixed 8-stage memory delay used in the G.726 ADPCM datapath: y(k) = x(k-d).
- d is selected at run time (0..DEPTH), and the line advances only on a sample strobe.
- Adds a synchronous flush and a fill-tracking valid flag, so downstream adaptation blocks can ignore RESET_STATE samples after reset/clear.
- Sits between per-sample producers (quantizer/scale-factor logic) and consumers needing x(k-d).

---
 rtl/prog_delay_line_if.sv | 27 ++
 rtl/prog_delay_line.sv | 96 +++++++++
 2 files changed

// File: rtl/prog_delay_line_if.sv
// Purpose : sample/tap/output bundle of the programmable delay line.
// Latency : none, wires only.
// Backpressure: none; en is a one-way sample strobe.
// Ports   : master drives en/clear/x/tap and observes y/y_valid/fill;
//           slave is the delay line itself.
interface prog_delay_line_if #(
  parameter int WIDTH = 2,
  parameter int TAPW  = 4
);
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] x;
  logic [TAPW-1:0]  tap;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic [TAPW-1:0]  fill;

  modport master (
    output en, clear, x, tap,
    input  y, y_valid, fill
  );

  modport slave (
    input  en, clear, x, tap,
    output y, y_valid, fill
  );
endinterface

// File: rtl/prog_delay_line.sv
// Purpose : run-time programmable delay y(k) = x(k-d), d = 0..DEPTH, with flush and fill tracking.
// Latency : d strobes; d = 0 is a combinational bypass of x.
// Backpressure: none; the line only advances on en, holds otherwise, clear wins over en.
// Ports   : clk, reset (async active-low), dl (slave: en, clear, x, tap -> y, y_valid, fill),
//           scan_enable/scan_in0..4 (DFT, unused), scan_out0..4 (tied low until scan insertion).
module prog_delay_line #(
  parameter int               WIDTH       = 2,
  parameter int               DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_STATE = '0,
  parameter int               TAPW        = 4
) (
  input  logic             clk,
  input  logic             reset,
  prog_delay_line_if.slave dl,
  input  logic             scan_enable,
  input  logic             scan_in0,
  input  logic             scan_in1,
  input  logic             scan_in2,
  input  logic             scan_in3,
  input  logic             scan_in4,
  output logic             scan_out0,
  output logic             scan_out1,
  output logic             scan_out2,
  output logic             scan_out3,
  output logic             scan_out4
);

  localparam logic [TAPW-1:0] DEPTH_T = TAPW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [TAPW-1:0]  fill_q;
  logic [TAPW-1:0]  fill_d;

  logic [TAPW-1:0]  tap_eff;
  logic [WIDTH-1:0] tap_dat;
  logic [WIDTH-1:0] y_dat;
  logic             y_vld;

  // Next state: clear beats en; with neither, everything holds.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    fill_d = fill_q;
    if (dl.clear) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = RESET_STATE;
      fill_d = '0;
    end else if (dl.en) begin
      stage_d[0] = dl.x;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      // Saturate so downstream can rely on fill never wrapping back to "empty".
      if (fill_q != DEPTH_T) fill_d = fill_q + TAPW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_STATE;
      fill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      fill_q <= fill_d;
    end
  end

  // Output path is purely combinational from state, tap and x, so a tap
  // change is visible in the same cycle without touching the stored samples.
  always_comb begin
    tap_eff = (dl.tap > DEPTH_T) ? DEPTH_T : dl.tap;
    // Compare-and-select mux keeps the tap index width independent of DEPTH.
    tap_dat = RESET_STATE;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_eff == TAPW'(i + 1)) tap_dat = stage_q[i];
    end
    if (tap_eff == '0) begin
      y_dat = dl.x;
      y_vld = 1'b1;
    end else begin
      y_dat = tap_dat;
      y_vld = (fill_q >= tap_eff);
    end
  end

  assign dl.y       = y_dat;
  assign dl.y_valid = y_vld;
  assign dl.fill    = fill_q;

  // Scan chain is stitched later; keep the pins alive but functionally inert.
  wire scan_unused = &{1'b0, scan_enable, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

endmodule
